// File: rtl/int_req_ctrl.sv
// Interrupt request sequencer feeding a vectored interrupt controller.
// Captures completion pulses as sticky pending bits and runs the accept/ack/return handshake.
module int_req_ctrl #(
    parameter int ACK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] done_in,
    input  logic       mask_we,
    input  logic [3:0] mask_wd,
    input  logic       cpu_ack,
    input  logic       int_ret,
    output logic       int_req,
    output logic       int_ack,
    output logic [3:0] done,
    output logic [1:0] serv_id,
    output logic [3:0] pending,
    output logic [3:0] mask,
    output logic       busy
);

    // state    | meaning
    // IDLE     | nothing requested, done mirrors active sources
    // REQ      | int_req raised, waiting for cpu_ack
    // ACK      | int_ack held for ACK_CYCLES, done frozen to serviced source
    // SERVICE  | handler running, done cleared, waiting for int_ret
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_SERVICE = 2'd3;

    logic [1:0] state;
    logic [3:0] cnt;
    logic [3:0] act;
    logic [3:0] clr;
    logic [1:0] top_id;
    logic       ack_last;

    assign act      = pending & mask;
    assign ack_last = (state == S_ACK) && (cnt == 4'd0);
    assign clr      = ack_last ? (4'b0001 << serv_id) : 4'b0000;

    always_comb begin
        top_id = 2'd0;
        if (act[3])      top_id = 2'd3;
        else if (act[2]) top_id = 2'd2;
        else if (act[1]) top_id = 2'd1;
        else             top_id = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            pending <= 4'b0000;
            mask    <= 4'b0000;
            serv_id <= 2'd0;
        end else begin
            // OR-ing done_in after the clear makes a same-cycle set win
            pending <= (pending & ~clr) | done_in;
            if (mask_we) mask <= mask_wd;
            case (state)
                S_IDLE: begin
                    if (|act) state <= S_REQ;
                end
                S_REQ: begin
                    if (cpu_ack && (|act)) begin
                        serv_id <= top_id;
                        cnt     <= 4'(ACK_CYCLES - 1);
                        state   <= S_ACK;
                    end else if (act == 4'b0000) begin
                        state <= S_IDLE;
                    end
                end
                S_ACK: begin
                    if (cnt == 4'd0) state <= S_SERVICE;
                    else             cnt   <= cnt - 4'd1;
                end
                S_SERVICE: begin
                    if (int_ret) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign int_req = (state == S_REQ);
    assign int_ack = (state == S_ACK);
    assign busy    = (state != S_IDLE);

    // done is decoded from registers only, so the controller never sees input glitches
    always_comb begin
        done = 4'b0000;
        case (state)
            S_IDLE, S_REQ: done = act;
            S_ACK:         done = 4'b0001 << serv_id;
            default:       done = 4'b0000;
        endcase
    end

endmodule

// File: tb/tb_int_req_ctrl.sv
// Bench for int_req_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model of the sequencer's handshake rules.
module tb_int_req_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] done_in;
    logic       mask_we;
    logic [3:0] mask_wd;
    logic       cpu_ack;
    logic       int_ret;

    logic       int_req, int_ack, busy;
    logic [3:0] done, pending, mask;
    logic [1:0] serv_id;

    logic       int_req3, int_ack3, busy3;
    logic [3:0] done3, pending3, mask3;
    logic [1:0] serv_id3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int_req_ctrl dut (
        .clk(clk), .rst(rst), .done_in(done_in), .mask_we(mask_we), .mask_wd(mask_wd),
        .cpu_ack(cpu_ack), .int_ret(int_ret), .int_req(int_req), .int_ack(int_ack),
        .done(done), .serv_id(serv_id), .pending(pending), .mask(mask), .busy(busy)
    );

    int_req_ctrl #(.ACK_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .done_in(done_in), .mask_we(mask_we), .mask_wd(mask_wd),
        .cpu_ack(cpu_ack), .int_ret(int_ret), .int_req(int_req3), .int_ack(int_ack3),
        .done(done3), .serv_id(serv_id3), .pending(pending3), .mask(mask3), .busy(busy3)
    );

    // Reference model (ACK_CYCLES = 2) of the handshake phases
    localparam int M_ACK = 2;
    int         m_phase;   // 0 idle, 1 requesting, 2 acknowledging, 3 servicing
    int         m_left;    // acknowledge cycles still to go, including the current one
    logic [3:0] m_pending, m_mask, m_act, m_clr, e_done;
    logic [1:0] m_serv;

    function automatic logic [1:0] highest(input logic [3:0] v);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    assign m_act = m_pending & m_mask;
    assign m_clr = (m_phase == 2 && m_left == 1) ? 4'(1 << m_serv) : 4'b0000;

    always_comb begin
        e_done = 4'b0000;
        if (m_phase == 0 || m_phase == 1) e_done = m_act;
        else if (m_phase == 2)            e_done = 4'(1 << m_serv);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_left <= 0; m_pending <= 4'b0; m_mask <= 4'b0; m_serv <= 2'd0;
        end else begin
            m_pending <= (m_pending & ~m_clr) | done_in;
            if (mask_we) m_mask <= mask_wd;
            if (m_phase == 0 && m_act != 0) m_phase <= 1;
            else if (m_phase == 1 && cpu_ack && m_act != 0) begin
                m_phase <= 2; m_left <= M_ACK; m_serv <= highest(m_act);
            end else if (m_phase == 1 && m_act == 0) m_phase <= 0;
            else if (m_phase == 2) begin
                if (m_left == 1) m_phase <= 3;
                m_left <= m_left - 1;
            end else if (m_phase == 3 && int_ret) m_phase <= 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        done_in = 4'b0; mask_we = 1'b0; mask_wd = 4'b0; cpu_ack = 1'b0; int_ret = 1'b0;
    endtask

    task automatic reset_and_mask(input logic [3:0] m);
        idle_inputs();
        rst = 1'b1; step(); step();
        rst = 1'b0;
        mask_we = 1'b1; mask_wd = m; step();
        mask_we = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; step(); step();
        n_cmp++;
        if ({int_req, int_ack, done, serv_id, pending, mask, busy} !== 17'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {int_req, int_ack, done, serv_id, pending, mask, busy});
        end
        n_cmp++;
        if ({int_req3, int_ack3, done3, serv_id3, pending3, mask3, busy3} !== 17'b0) begin
            n_err++;
            $display("FAIL reset_outputs_ack3: got %h want 0",
                     {int_req3, int_ack3, done3, serv_id3, pending3, mask3, busy3});
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        reset_and_mask(4'b1111);
        done_in = 4'b0010; step(); done_in = 4'b0;
        n_cmp++;
        if (pending !== 4'b0010 || int_req !== 1'b0) begin
            n_err++; $display("FAIL single_pending: got p=%b req=%b want p=0010 req=0", pending, int_req);
        end
        step();
        n_cmp++;
        if (int_req !== 1'b1) begin n_err++; $display("FAIL single_req: got %b want 1", int_req); end
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        n_cmp++;
        if (int_ack !== 1'b1 || done !== 4'b0010 || serv_id !== 2'd1 || int_req !== 1'b0) begin
            n_err++;
            $display("FAIL single_ack1: got ack=%b done=%b id=%0d req=%b want 1 0010 1 0",
                     int_ack, done, serv_id, int_req);
        end
        step();
        n_cmp++;
        if (int_ack !== 1'b1 || done !== 4'b0010) begin
            n_err++; $display("FAIL single_ack2: got ack=%b done=%b want 1 0010", int_ack, done);
        end
        step();
        n_cmp++;
        if (int_ack !== 1'b0 || pending !== 4'b0 || done !== 4'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_service: got ack=%b p=%b done=%b busy=%b want 0 0000 0000 1",
                     int_ack, pending, done, busy);
        end
        int_ret = 1'b1; step(); int_ret = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || int_req !== 1'b0) begin
            n_err++; $display("FAIL single_ret: got busy=%b req=%b want 0 0", busy, int_req);
        end
    endtask

    task automatic test_priority();
        reset_and_mask(4'b1111);
        done_in = 4'b1001; step(); done_in = 4'b0; step();
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        n_cmp++;
        if (serv_id !== 2'd3 || done !== 4'b1000) begin
            n_err++; $display("FAIL prio_first: got id=%0d done=%b want 3 1000", serv_id, done);
        end
        step(); step();
        n_cmp++;
        if (pending !== 4'b0001 || int_ack !== 1'b0) begin
            n_err++; $display("FAIL prio_pending: got p=%b ack=%b want 0001 0", pending, int_ack);
        end
        int_ret = 1'b1; step(); int_ret = 1'b0; step();
        n_cmp++;
        if (int_req !== 1'b1) begin n_err++; $display("FAIL prio_rereq: got %b want 1", int_req); end
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        n_cmp++;
        if (serv_id !== 2'd0 || done !== 4'b0001) begin
            n_err++; $display("FAIL prio_second: got id=%0d done=%b want 0 0001", serv_id, done);
        end
        step(); step();
        n_cmp++;
        if (pending !== 4'b0000) begin n_err++; $display("FAIL prio_drain: got %b want 0000", pending); end
    endtask

    task automatic test_mask();
        reset_and_mask(4'b0001);
        done_in = 4'b0100; step(); done_in = 4'b0; step(); step();
        n_cmp++;
        if (pending !== 4'b0100 || int_req !== 1'b0 || done !== 4'b0000) begin
            n_err++;
            $display("FAIL mask_block: got p=%b req=%b done=%b want 0100 0 0000", pending, int_req, done);
        end
        mask_we = 1'b1; mask_wd = 4'b0100; step(); mask_we = 1'b0;
        n_cmp++;
        if (mask !== 4'b0100 || int_req !== 1'b0 || done !== 4'b0100) begin
            n_err++;
            $display("FAIL mask_write: got m=%b req=%b done=%b want 0100 0 0100", mask, int_req, done);
        end
        step();
        n_cmp++;
        if (int_req !== 1'b1) begin n_err++; $display("FAIL mask_req: got %b want 1", int_req); end
        mask_we = 1'b1; mask_wd = 4'b0000; step(); mask_we = 1'b0; step();
        n_cmp++;
        if (int_req !== 1'b0 || busy !== 1'b0 || pending !== 4'b0100) begin
            n_err++;
            $display("FAIL mask_withdraw: got req=%b busy=%b p=%b want 0 0 0100", int_req, busy, pending);
        end
    endtask

    task automatic test_collision();
        reset_and_mask(4'b1111);
        done_in = 4'b0010; step(); done_in = 4'b0; step();
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0; step();
        done_in = 4'b0010; step(); done_in = 4'b0;
        n_cmp++;
        if (pending !== 4'b0010 || int_ack !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL collide_keep: got p=%b ack=%b busy=%b want 0010 0 1", pending, int_ack, busy);
        end
        int_ret = 1'b1; step(); int_ret = 1'b0; step();
        n_cmp++;
        if (int_req !== 1'b1) begin n_err++; $display("FAIL collide_rereq: got %b want 1", int_req); end
    endtask

    task automatic test_spurious();
        reset_and_mask(4'b1111);
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || int_ack !== 1'b0) begin
            n_err++; $display("FAIL spur_idle_ack: got busy=%b ack=%b want 0 0", busy, int_ack);
        end
        done_in = 4'b0001; step(); done_in = 4'b0; step();
        int_ret = 1'b1; step(); int_ret = 1'b0;
        n_cmp++;
        if (int_req !== 1'b1 || int_ack !== 1'b0) begin
            n_err++; $display("FAIL spur_req_ret: got req=%b ack=%b want 1 0", int_req, int_ack);
        end
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0; step(); step();
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        n_cmp++;
        if (int_ack !== 1'b0 || busy !== 1'b1 || int_req !== 1'b0) begin
            n_err++;
            $display("FAIL spur_service_ack: got ack=%b busy=%b req=%b want 0 1 0", int_ack, busy, int_req);
        end
        int_ret = 1'b1; step(); int_ret = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL spur_ret: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_ack();
        reset_and_mask(4'b1111);
        done_in = 4'b0100; step(); done_in = 4'b0; step();
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0; step();
        n_cmp++;
        if (int_ack3 !== 1'b1 || done3 !== 4'b0100 || serv_id3 !== 2'd2) begin
            n_err++;
            $display("FAIL midack_pre: got ack=%b done=%b id=%0d want 1 0100 2", int_ack3, done3, serv_id3);
        end
        rst = 1'b1; step();
        n_cmp++;
        if ({int_req3, int_ack3, done3, serv_id3, pending3, mask3, busy3} !== 17'b0) begin
            n_err++;
            $display("FAIL midack_reset: got %h want 0",
                     {int_req3, int_ack3, done3, serv_id3, pending3, mask3, busy3});
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        reset_and_mask(4'b1111);
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            done_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            mask_we = ($urandom_range(0, 15) == 0);
            mask_wd = 4'($urandom_range(0, 15));
            cpu_ack = ($urandom_range(0, 2) == 0);
            int_ret = ($urandom_range(0, 3) == 0);
            step();
            n_cmp++;
            if ({int_req, int_ack, busy, done, serv_id, pending, mask} !==
                {m_phase == 1, m_phase == 2, m_phase != 0, e_done, m_serv, m_pending, m_mask}) begin
                n_err++;
                $display("FAIL random_cycle%0d: got req=%b ack=%b busy=%b done=%b id=%0d p=%b m=%b want %b %b %b %b %0d %b %b",
                         i, int_req, int_ack, busy, done, serv_id, pending, mask,
                         m_phase == 1, m_phase == 2, m_phase != 0, e_done, m_serv, m_pending, m_mask);
            end
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_collision();
        test_spurious();
        test_reset_mid_ack();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
